// File: rtl/regfile_dump_tx_pkg.sv
// Shared types and constants for the register-file dump transmitter.
// Imported by the top level and the byte serializer.
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    SEND_HI,
    SEND_LO
  } dumpState_t;

  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam int FRAME_BITS = 10;
  localparam int BIT_W = $clog2(FRAME_BITS);

endpackage

// File: rtl/regfile_dump_tx_if.sv
// Register-file dump bus: read port toward the register file,
// serial pin and status toward the board / host.
interface regfile_dump_tx_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);

  logic              dumpStart;
  logic [ADDR_W-1:0] dumpReg;
  logic [DATA_W-1:0] dumpData;
  logic              txOut;
  logic              dumpBusy;
  logic              dumpDone;

  modport master (
    input  dumpStart,
    input  dumpData,
    output dumpReg,
    output txOut,
    output dumpBusy,
    output dumpDone
  );

  modport slave (
    output dumpStart,
    output dumpData,
    input  dumpReg,
    input  txOut,
    input  dumpBusy,
    input  dumpDone
  );

endinterface

// File: rtl/regfile_dump_tx_uart.sv
// 8N1 LSB-first byte serializer; ready in the last stop-bit cycle
// so a new byte can follow with no idle gap.
module uart_byte_tx
  import regfile_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] byteIn,
  output logic       txOut,
  output logic       ready
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bitIdx;
  logic [8:0]       shifter;
  logic             txQ;
  logic             bitEnd;
  logic             lastBit;

  assign bitEnd  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign lastBit = (bitIdx == BIT_W'(FRAME_BITS - 1));
  assign ready   = !active || (bitEnd && lastBit);
  assign txOut   = txQ;

  // shifter holds the bits still to go: data then stop
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      active  <= 1'b0;
      cnt     <= '0;
      bitIdx  <= '0;
      shifter <= '1;
      txQ     <= 1'b1;
    end else if (load && ready) begin
      active  <= 1'b1;
      cnt     <= '0;
      bitIdx  <= '0;
      shifter <= {1'b1, byteIn};
      txQ     <= 1'b0;
    end else if (active) begin
      if (!bitEnd) begin
        cnt <= cnt + 1'b1;
      end else if (!lastBit) begin
        cnt     <= '0;
        bitIdx  <= bitIdx + 1'b1;
        txQ     <= shifter[0];
        shifter <= {1'b1, shifter[8:1]};
      end else begin
        active <= 1'b0;
        cnt    <= '0;
        bitIdx <= '0;
        txQ    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_tx.sv
// Dumps every register through a spare read port as a framed
// serial stream: header, then each register high byte first.
module regfile_dump_tx
  import regfile_dump_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         NUM_REGS     = 8,
  parameter int         ADDR_W       = 3,
  parameter int         DATA_W       = 16,
  parameter logic [7:0] HEADER       = HEADER_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  regfile_dump_tx_if.master bus
);

  dumpState_t        state;
  dumpState_t        nextState;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] holdD;
  logic              doneQ;
  logic              uLoad;
  logic [7:0]        uByte;
  logic              uReady;
  logic              lastReg;

  assign lastReg = (idx == ADDR_W'(NUM_REGS - 1));
  // LOAD forwards the live read data so the high byte starts at once
  assign holdD   = (state == LOAD) ? bus.dumpData : hold;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.dumpStart) nextState = HDR;
      HDR:     if (uReady) nextState = LOAD;
      LOAD:    nextState = SEND_HI;
      SEND_HI: if (uReady) nextState = SEND_LO;
      SEND_LO: if (uReady) nextState = lastReg ? IDLE : LOAD;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    uLoad = 1'b0;
    uByte = HEADER;
    unique case (1'b1)
      state == IDLE: uLoad = bus.dumpStart;
      state == LOAD: begin
        uLoad = 1'b1;
        uByte = holdD[DATA_W-1 -: 8];
      end
      state == SEND_HI: begin
        uLoad = uReady;
        uByte = holdD[7:0];
      end
      default: uLoad = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx   <= '0;
      hold  <= '0;
      doneQ <= 1'b0;
    end else begin
      hold  <= holdD;
      doneQ <= (state == SEND_LO) && uReady && lastReg;
      if (nextState == LOAD)
        idx <= (state == HDR) ? '0 : idx + 1'b1;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTx (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (uLoad),
    .byteIn (uByte),
    .txOut  (bus.txOut),
    .ready  (uReady)
  );

  assign bus.dumpReg  = idx;
  assign bus.dumpBusy = (state != IDLE);
  assign bus.dumpDone = doneQ;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: two instances (4 and 2 clocks per bit)
// against a cycle-offset stream model and a UART receiver.
module tb_regfile_dump_tx;

  localparam int CA = 4;
  localparam int CB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  regfile_dump_tx_if #(.ADDR_W(3), .DATA_W(16)) bus0 ();
  regfile_dump_tx_if #(.ADDR_W(3), .DATA_W(16)) bus1 ();

  logic [1:0]  rstA   = 2'b00;
  logic [1:0]  startA = 2'b00;
  logic [1:0]  wrEn   = 2'b00;
  logic [2:0]  wrAddr [2];
  logic [15:0] wrData [2];
  logic [15:0] rf [2][8];

  regfile_dump_tx #(.CLKS_PER_BIT(CA)) dut0 (
    .clock(clk), .reset_n(rstA[0]), .bus(bus0)
  );
  regfile_dump_tx #(.CLKS_PER_BIT(CB)) dut1 (
    .clock(clk), .reset_n(rstA[1]), .bus(bus1)
  );

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (wrEn[i]) rf[i][wrAddr[i]] <= wrData[i];

  assign bus0.dumpStart = startA[0];
  assign bus1.dumpStart = startA[1];
  assign bus0.dumpData  = rf[0][bus0.dumpReg];
  assign bus1.dumpData  = rf[1][bus1.dumpReg];

  logic [1:0] txA, busyA, doneA;
  logic [2:0] regA [2];
  assign txA   = {bus1.txOut, bus0.txOut};
  assign busyA = {bus1.dumpBusy, bus0.dumpBusy};
  assign doneA = {bus1.dumpDone, bus0.dumpDone};
  assign regA[0] = bus0.dumpReg;
  assign regA[1] = bus1.dumpReg;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: position in the dump is a cycle offset t from acceptance
  function automatic int cpbOf(input int i);
    return (i == 0) ? CA : CB;
  endfunction
  function automatic int totalOf(input int c);
    return 170 * c + 8;
  endfunction
  function automatic bit isLoad(input int c, input int t);
    return (t >= 10 * c) && ((t - 10 * c) % (20 * c + 1) == 0);
  endfunction
  function automatic int regOf(input int c, input int t);
    return (t - 10 * c) / (20 * c + 1);
  endfunction

  logic        mActive [2];
  logic        mDone [2];
  logic [2:0]  mReg [2];
  int          mT [2];
  logic [15:0] snap [2][8];

  function automatic logic bitAt(input int i, input int t);
    int c, u, v, w, b, r;
    logic [7:0] by;
    c = cpbOf(i);
    if (t < 10 * c) begin
      by = 8'hA5;
      b  = t / c;
    end else begin
      u = t - 10 * c;
      r = u / (20 * c + 1);
      v = u % (20 * c + 1);
      if (v == 0) return 1'b1;
      w  = v - 1;
      by = (w < 10 * c) ? snap[i][r][15:8] : snap[i][r][7:0];
      b  = (w % (10 * c)) / c;
    end
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  always @(posedge clk) begin : mdl
    int c, t;
    for (int i = 0; i < 2; i++) begin
      c = cpbOf(i);
      t = mT[i];
      mDone[i] <= 1'b0;
      if (!rstA[i]) begin
        mActive[i] <= 1'b0;
        mReg[i]    <= 3'd0;
      end else if (mActive[i]) begin
        if (isLoad(c, t)) snap[i][regOf(c, t)] <= rf[i][regOf(c, t)];
        t = t + 1;
        mT[i] <= t;
        if (t == totalOf(c)) begin
          mActive[i] <= 1'b0;
          mDone[i]   <= 1'b1;
        end else if (isLoad(c, t)) begin
          mReg[i] <= 3'(regOf(c, t));
        end
      end else if (startA[i]) begin
        mActive[i] <= 1'b1;
        mT[i]      <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tx%0d", i), txA[i],
            mActive[i] ? bitAt(i, mT[i]) : 1'b1);
      check($sformatf("busy%0d", i), busyA[i], mActive[i]);
      check($sformatf("done%0d", i), doneA[i], mDone[i]);
      check($sformatf("reg%0d", i), regA[i], mReg[i]);
    end
  end

  // Serial receiver decoding txOut into bytes
  logic [7:0] rxq0 [$];
  logic [7:0] rxq1 [$];

  task automatic rxLoop(input int i, input int c);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txA[i] == 1'b0) begin
        for (int j = 0; j < 8; j++) begin
          repeat (c) @(negedge clk);
          b[j] = txA[i];
        end
        repeat (c) @(negedge clk);
        check($sformatf("stop%0d", i), txA[i], 1);
        if (i == 0) rxq0.push_back(b);
        else        rxq1.push_back(b);
      end
    end
  endtask

  initial rxLoop(0, CA);
  initial rxLoop(1, CB);

  logic [15:0] expVals [8];

  task automatic checkStream(input int i, input string tag);
    logic [7:0] got, exp;
    int n;
    n = (i == 0) ? rxq0.size() : rxq1.size();
    check({tag, "_len"}, n, 17);
    for (int k = 0; k < 17 && k < n; k++) begin
      if (i == 0) got = rxq0.pop_front();
      else        got = rxq1.pop_front();
      if (k == 0)          exp = 8'hA5;
      else if (k % 2 == 1) exp = expVals[(k - 1) / 2][15:8];
      else                 exp = expVals[(k - 1) / 2][7:0];
      check($sformatf("%s_b%0d", tag, k), got, exp);
    end
    if (i == 0) rxq0.delete();
    else        rxq1.delete();
  endtask

  task automatic preload(input int i);
    for (int r = 0; r < 8; r++) begin
      wrEn[i]   = 1'b1;
      wrAddr[i] = 3'(r);
      wrData[i] = expVals[r];
      @(negedge clk);
    end
    wrEn[i] = 1'b0;
  endtask

  task automatic waitDone(input int i, output int busyN);
    int n;
    busyN = 0;
    n = 0;
    while (doneA[i] !== 1'b1 && n < 5000) begin
      if (busyA[i]) busyN++;
      @(negedge clk);
      n++;
    end
    check($sformatf("done_seen%0d", i), doneA[i], 1);
  endtask

  task automatic kick(input int i);
    startA[i] = 1'b1;
    @(negedge clk);
    startA[i] = 1'b0;
  endtask

  task automatic randomDump(input int i);
    int n;
    n = 0;
    startA[i] = 1'b1;
    @(negedge clk);
    startA[i] = 1'b0;
    while (doneA[i] !== 1'b1 && n < 5000) begin
      wrEn[i] = ($urandom_range(7) == 0);
      wrAddr[i] = 3'($urandom_range(7));
      wrData[i] = 16'($urandom);
      @(negedge clk);
      n++;
    end
    wrEn[i] = 1'b0;
    check($sformatf("rnd_done%0d", i), doneA[i], 1);
    for (int r = 0; r < 8; r++) expVals[r] = snap[i][r];
    checkStream(i, "rnd");
  endtask

  initial begin
    int bn, dn;
    wrAddr[0] = 3'd0; wrAddr[1] = 3'd0;
    wrData[0] = 16'd0; wrData[1] = 16'd0;
    for (int r = 0; r < 8; r++) expVals[r] = 16'd0;
    @(negedge clk);
    preload(0);
    preload(1);
    check("rst_tx", txA, 2'b11);
    check("rst_busy", busyA, 2'b00);
    check("rst_reg", regA[0], 0);
    rstA = 2'b11;
    repeat (100) @(negedge clk);
    check("idle_tx", txA, 2'b11);
    check("idle_done", doneA, 2'b00);

    // Directed dump, 4 clocks per bit
    for (int r = 0; r < 8; r++) expVals[r] = 16'(16'h1111 * r);
    expVals[4] = 16'h0011;
    preload(0);
    kick(0);
    check("start_tx", txA[0], 0);
    check("start_busy", busyA[0], 1);
    waitDone(0, bn);
    check("busy_len4", bn, 688);
    checkStream(0, "dir");
    @(negedge clk);
    check("done_pulse", doneA[0], 0);

    // dumpStart held through the dump, restart in the done cycle
    startA[0] = 1'b1;
    @(negedge clk);
    waitDone(0, bn);
    check("hold_len", bn, 688);
    checkStream(0, "hold1");
    @(negedge clk);
    check("restart_tx", txA[0], 0);
    check("restart_busy", busyA[0], 1);
    startA[0] = 1'b0;
    waitDone(0, bn);
    checkStream(0, "hold2");

    // Writes during the dump
    for (int r = 0; r < 8; r++) expVals[r] = 16'(16'h1357 * (r + 1));
    preload(0);
    kick(0);
    repeat (130) @(negedge clk);
    wrEn[0] = 1'b1; wrAddr[0] = 3'd3; wrData[0] = 16'hBEEF;
    @(negedge clk);
    wrEn[0] = 1'b0;
    repeat (202 - 131) @(negedge clk);
    check("load2_reg", regA[0], 2);
    wrEn[0] = 1'b1; wrAddr[0] = 3'd2; wrData[0] = 16'hDEAD;
    @(negedge clk);
    wrEn[0] = 1'b0;
    waitDone(0, bn);
    expVals[3] = 16'hBEEF;
    checkStream(0, "wr");
    expVals[2] = 16'hDEAD;

    // Reset in the middle of r5's low byte
    @(negedge clk);
    kick(0);
    repeat (500) @(negedge clk);
    rstA[0] = 1'b0;
    @(negedge clk);
    rstA[0] = 1'b1;
    check("mid_tx", txA[0], 1);
    check("mid_busy", busyA[0], 0);
    check("mid_reg", regA[0], 0);
    dn = 0;
    for (int k = 0; k < 60; k++) begin
      dn += int'(doneA[0]);
      @(negedge clk);
    end
    check("mid_nodone", dn, 0);
    rxq0.delete();
    kick(0);
    waitDone(0, bn);
    check("fresh_len", bn, 688);
    checkStream(0, "fresh");

    // 2 clocks per bit
    for (int r = 0; r < 8; r++) expVals[r] = 16'($urandom);
    preload(1);
    kick(1);
    waitDone(1, bn);
    check("busy_len2", bn, 348);
    checkStream(1, "c2");

    // Random dumps with random concurrent writes
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      randomDump(1);
    end
    @(negedge clk);
    randomDump(0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
